// File: rtl/pipe_reg_if.sv
// pipe_reg_if: producer/consumer handshake, flush and occupancy bundle for pipe_reg
interface pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             flush;
  logic [CW-1:0]    count;
  modport master (
    output in_valid, d, out_ready, flush,
    input  in_ready, out_valid, q, count
  );
  modport slave (
    input  in_valid, d, out_ready, flush,
    output in_ready, out_valid, q, count
  );
endinterface

// File: rtl/pipe_reg.sv
// pipe_reg: elastic, stallable, flushable chain of DEPTH valid/ready register stages
module pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic       clk,
  input logic       reset,
  pipe_reg_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] w_adv;
  logic [CW-1:0]    r_count;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_acc;
  logic             w_del;
  // a stage moves forward when it holds data and its successor is empty or itself moving
  always_comb begin
    logic c;
    w_adv = '0;
    c = r_vld[DEPTH-1] & bus.out_ready;
    w_adv[DEPTH-1] = c;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      c = r_vld[i] & (~r_vld[i+1] | c);
      w_adv[i] = c;
    end
  end
  assign w_in_ready    = ~bus.flush & (~r_vld[0] | w_adv[0]);
  assign w_out_valid   = r_vld[DEPTH-1] & ~bus.flush;
  assign w_acc         = bus.in_valid & w_in_ready;
  assign w_del         = w_out_valid & bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.q         = r_data[DEPTH-1];
  assign bus.count     = r_count;
  // stage registers: reset preloads data, flush only drops valids, otherwise shift on advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
    end else if (bus.flush) begin
      r_vld <= '0;
    end else begin
      if (w_acc) begin
        r_data[0] <= bus.d;
        r_vld[0]  <= 1'b1;
      end else if (w_adv[0]) begin
        r_vld[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i-1]) begin
          r_data[i] <= r_data[i-1];
          r_vld[i]  <= 1'b1;
        end else if (w_adv[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end
  // occupancy tracks accepts minus deliveries; the handshake keeps it within 0..DEPTH
  always_ff @(posedge clk) begin
    if (reset || bus.flush) r_count <= '0;
    else r_count <= (w_acc & ~w_del) ? r_count + CW'(1) : (w_del & ~w_acc) ? r_count - CW'(1) : r_count;
  end
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: table-driven check of pipe_reg at DEPTH=4 and DEPTH=1 plus latency sequences
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_reg_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  pipe_reg_if #(.WIDTH(8), .DEPTH(1)) b1 ();
  pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u4 (.clk(clk), .reset(rst), .bus(b4.slave));
  pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u1 (.clk(clk), .reset(rst), .bus(b1.slave));
  typedef struct {
    bit sel, chk, rst, iv, ordy, fl;
    logic [7:0] d;
    bit ir, ov;
    logic [7:0] q;
    int cnt;
  } row_t;
  row_t rows[$];
  int errors = 0;
  int checks = 0;
  task automatic v(input bit sel, chk, r, iv, input logic [7:0] d, input bit ordy, fl, ir, ov,
                   input logic [7:0] q, input int cnt);
    row_t x;
    x.sel = sel; x.chk = chk; x.rst = r; x.iv = iv; x.d = d; x.ordy = ordy; x.fl = fl;
    x.ir = ir; x.ov = ov; x.q = q; x.cnt = cnt;
    rows.push_back(x);
  endtask
  task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, i, got, exp);
    end
  endtask
  task automatic drive(input bit r, iv, input logic [7:0] d, input bit ordy, fl);
    rst = r;
    b4.in_valid = iv; b4.d = d; b4.out_ready = ordy; b4.flush = fl;
    b1.in_valid = iv; b1.d = d; b1.out_ready = ordy; b1.flush = fl;
  endtask
  initial begin
    int lat4, lat1;
    logic [7:0] q4;
    drive(1, 0, 8'h00, 0, 0);
    v(0,0,1,1,8'hAA,0,0, 0,0,8'h00,0);
    v(0,1,1,1,8'hAA,0,0, 1,0,8'h00,0);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h00,0);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h00,0);
    for (int k = 0; k < 8; k++)
      v(0,1,0,1,8'(k+1),1,0, 1,k>=4, k>=4 ? 8'(k-3) : 8'h00, k<4 ? k : 4);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h05,4);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h06,3);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h07,2);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h08,1);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h08,0);
    for (int k = 0; k < 4; k++) v(0,1,0,1,8'(8'h10+k),0,0, 1,0,8'h08,k);
    v(0,1,0,1,8'h14,0,0, 0,1,8'h10,4);
    v(0,1,0,1,8'h14,0,0, 0,1,8'h10,4);
    v(0,1,0,1,8'h14,1,0, 1,1,8'h10,4);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h11,4);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h12,3);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h13,2);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h14,1);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h14,0);
    v(0,1,0,1,8'h21,0,0, 1,0,8'h14,0);
    v(0,1,0,0,8'h00,0,0, 1,0,8'h14,1);
    v(0,1,0,0,8'h00,0,0, 1,0,8'h14,1);
    v(0,1,0,1,8'h22,0,0, 1,0,8'h14,1);
    v(0,1,0,0,8'h00,0,0, 1,1,8'h21,2);
    v(0,1,0,0,8'h00,0,0, 1,1,8'h21,2);
    v(0,1,0,0,8'h00,0,0, 1,1,8'h21,2);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h21,2);
    v(0,1,0,0,8'h00,1,0, 1,1,8'h22,1);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h22,0);
    for (int k = 0; k < 3; k++) v(0,1,0,1,8'(8'h41+k),0,0, 1,0,8'h22,k);
    v(0,1,0,1,8'h44,1,1, 0,0,8'h22,3);
    for (int k = 0; k < 4; k++) v(0,1,0,0,8'h00,1,0, 1,0,8'h22,0);
    for (int k = 0; k < 4; k++) v(0,1,0,1,8'(8'h51+k),0,0, 1,0,8'h22,k);
    v(0,1,1,1,8'h55,0,0, 0,1,8'h51,4);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h00,0);
    v(0,1,0,0,8'h00,1,0, 1,0,8'h00,0);
    v(1,1,1,1,8'hAA,1,0, 1,0,8'h00,0);
    v(1,1,1,1,8'hAA,1,0, 1,0,8'h00,0);
    v(1,1,0,1,8'h31,1,0, 1,0,8'h00,0);
    v(1,1,0,1,8'h32,1,0, 1,1,8'h31,1);
    v(1,1,0,1,8'h33,1,0, 1,1,8'h32,1);
    v(1,1,0,0,8'h00,1,0, 1,1,8'h33,1);
    v(1,1,0,1,8'h34,0,0, 1,0,8'h33,0);
    v(1,1,0,1,8'h35,0,0, 0,1,8'h34,1);
    v(1,1,0,1,8'h35,1,0, 1,1,8'h34,1);
    v(1,1,0,0,8'h00,1,0, 1,1,8'h35,1);
    v(1,1,0,0,8'h00,1,0, 1,0,8'h35,0);
    v(1,1,0,1,8'h36,0,0, 1,0,8'h35,0);
    v(1,1,1,1,8'h37,0,0, 0,1,8'h36,1);
    v(1,1,0,0,8'h00,1,0, 1,0,8'h00,0);
    v(1,1,0,1,8'h38,0,0, 1,0,8'h00,0);
    v(1,1,0,1,8'h39,1,1, 0,0,8'h38,1);
    v(1,1,0,0,8'h00,1,0, 1,0,8'h38,0);
    @(posedge clk); #1;
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i].rst, rows[i].iv, rows[i].d, rows[i].ordy, rows[i].fl);
      @(negedge clk);
      if (rows[i].chk) begin
        cmp("in_ready",  i, rows[i].sel ? b1.in_ready  : b4.in_ready,  rows[i].ir);
        cmp("out_valid", i, rows[i].sel ? b1.out_valid : b4.out_valid, rows[i].ov);
        cmp("q",         i, rows[i].sel ? b1.q         : b4.q,         rows[i].q);
        cmp("count",     i, rows[i].sel ? 32'(b1.count) : 32'(b4.count), rows[i].cnt);
      end
      @(posedge clk); #1;
    end
    drive(0, 1, 8'h5A, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 1, 0);
    lat4 = -1; lat1 = -1; q4 = 8'h00;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (lat4 < 0 && b4.out_valid === 1'b1) begin lat4 = n; q4 = b4.q; end
      if (lat1 < 0 && b1.out_valid === 1'b1) lat1 = n;
      @(posedge clk); #1;
    end
    cmp("latency_d4", 0, lat4, 3);
    cmp("latency_q_d4", 0, q4, 8'h5A);
    cmp("latency_d1", 0, lat1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic register pipeline: a chain of `DEPTH` D-register stages, each `WIDTH` bits wide, with per-stage valid bits and a valid/ready handshake on both sides. It generalises the single D flip-flop into a stallable, flushable delay line. It sits between a producer and a consumer that need a fixed-latency registered path which can absorb backpressure. Internal bubbles collapse, so stages fill whenever the output is stalled.

## Interface
- `WIDTH`, 8, data width in bits (>= 1)
- `DEPTH`, 4, number of register stages (>= 1)
- `RESET_VAL`, 0, value loaded into every data register on reset
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  producer offers `d`
- `in_ready`  output  1  pipeline accepts `d` this cycle
- `d`  input  WIDTH  input data
- `out_valid`  output  1  `q` holds valid data
- `out_ready`  input  1  consumer takes `q` this cycle
- `q`  output  WIDTH  output data (last stage register)
- `flush`  input  1  discard all held data
- `count`  output  $clog2(DEPTH+1)  number of valid stages currently held

## Operation
- Stage registers: `data[0..DEPTH-1]`, `vld[0..DEPTH-1]`. Stage 0 is the input side; stage DEPTH-1 drives `q`/`out_valid`.
- Advance rule: `adv[DEPTH-1] = vld[DEPTH-1] & out_ready`. `adv[i] = vld[i] & (~vld[i+1] | adv[i+1])` for i < DEPTH-1.
- Stage i+1 loads `data[i]` and sets `vld[i+1]=1` when `adv[i]`. Otherwise it clears `vld[i+1]` if `adv[i+1]`, or holds if neither applies.
- `in_ready = ~flush & (~vld[0] | adv[0])`. Stage 0 loads `d` when `in_valid & in_ready`.
- Accept: `in_valid & in_ready`. Deliver: `out_valid & out_ready`.
- Data registers only load on an advance or accept. They never change otherwise, so `q` is stable while `out_valid & ~out_ready`.
- `out_valid = vld[DEPTH-1] & ~flush`. `q = data[DEPTH-1]`.
- `count` is a register:
  - +1 on accept only.
  - -1 on deliver only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0.
- Flush (`flush=1`):
  - `in_ready` and `out_valid` are forced low that cycle, so no transfer occurs.
  - Next edge: all `vld` = 0 and `count` = 0.
  - Data registers hold their values.
- Reset (`reset=1`) has priority over flush and all transfers. Next edge: all `vld`=0, all data = `RESET_VAL`, `count`=0.
- Ordering: data leaves in exactly the order accepted. No loss or duplication except by flush or reset.

## Timing
- Reset values: `out_valid`=0, `q`=RESET_VAL, `count`=0. `in_ready`=1 after reset once `reset` and `flush` are low. During reset `in_ready` follows its combinational equation, but any accept in that cycle is discarded.
- Latency with `out_ready` held high: word accepted at edge N appears on `q` with `out_valid`=1 after edge N+DEPTH-1 and is delivered at edge N+DEPTH. Each word therefore spends DEPTH cycles in the pipeline.
- Throughput: one word per cycle sustained when `out_ready`=1.
- Full (`count`=DEPTH, `out_ready`=0): `in_ready`=0.
- Full with `out_ready`=1: `in_ready`=1. Simultaneous accept and deliver leave `count`=DEPTH.
- Empty: `out_valid`=0; `q` retains the last value.
- `in_ready` depends combinationally on `out_ready`, `flush` and state. `out_valid` and `q` depend only on registers and `flush`.
- DEPTH=1: behaves as a single-entry register. With `out_ready`=1 it accepts and delivers in the same cycle.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid`=1, `d`=8'hAA -> `out_valid`=0, `q`=8'h00, `count`=0, and no word emerges afterwards.
- **Stream (DEPTH=4):** `out_ready`=1, push 8'h01..8'h08 on consecutive cycles -> `q` shows 8'h01..8'h08 in order. The first arrives on `q` 3 edges after its accept and is delivered at the 4th. `count` settles at 4.
- **Backpressure:** `out_ready`=0, offer 8'h10..8'h14 -> 8'h10..8'h13 accepted, `in_ready`=0 on the 5th offer, `count`=4, `q`=8'h10 stable. Then raise `out_ready` -> 8'h10..8'h14 delivered in order.
- **Bubble collapse:** push 8'h21, idle 2 cycles, push 8'h22, with `out_ready`=0 -> both words reach stages 3 and 2 and `count`=2. Release `out_ready` -> consecutive delivery of 8'h21 then 8'h22.
- **Flush:** with `count`=3, assert `flush` 1 cycle with `in_valid`=1 and `out_ready`=1 -> `in_ready`=0 and `out_valid`=0 that cycle. Next cycle `count`=0 and no old data ever appears on `q`.
- **Mid-operation reset, DEPTH=1:**
  - Full pipeline, assert `reset` -> next cycle empty and `q`=RESET_VAL.
  - Rebuild with DEPTH=1 and stream 8'h31..8'h33 with `out_ready`=1 -> one word per cycle, `count` steady at 1.
